// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. It owns the PC, drives the address of
// a synchronous ROM, absorbs the one-cycle read latency and hands fetched
// words to decode through a 2-entry valid/ready output queue. A redirect
// squashes every in-flight and queued fetch.
module fetch_unit #(
  parameter int          Width     = 32,
  parameter int          Depth     = 32,
  parameter logic [31:0] ResetPc   = 32'h0,
  localparam int         AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [AddrWidth-1:0] rom_addr,
  input  logic [Width-1:0]     rom_data,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Width-1:0]     out_instr,
  output logic [31:0]          out_pc,
  output logic                 out_fault
);

  // First byte address past the end of the ROM; fetches at or above it fault.
  localparam logic [31:0] RomBytes = 32'(Depth * 4);

  typedef struct packed {
    logic [Width-1:0] instr;
    logic [31:0]      pc;
    logic             fault;
  } entry_t;

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [1:0]  count_q, count_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  level_after_pop;
  entry_t      resp_entry;

  assign pop  = (count_q != 2'd0) & out_ready;
  assign push = inflight_q & ~redirect_valid;

  // Queued entries plus the outstanding read, minus what leaves this cycle,
  // must leave room for one more response before a new read is issued.
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = ~redirect_valid & (occupancy < 3'd2);

  assign level_after_pop = count_q - {1'b0, pop};

  // Out-of-range reads are reported as faults with a zero instruction word.
  always_comb begin
    if (inflight_pc_q >= RomBytes) begin
      resp_entry = '{instr: '0, pc: inflight_pc_q, fault: 1'b1};
    end else begin
      resp_entry = '{instr: rom_data, pc: inflight_pc_q, fault: 1'b0};
    end
  end

  // Next-state logic for the PC, the outstanding-read tracker and the queue.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (redirect_valid) begin
      // The consumer keeps any entry it pops now; everything else is dropped.
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end else begin
        inflight_d = 1'b0;
      end

      if (pop) begin
        head_d = tail_q;
      end

      if (push) begin
        if (level_after_pop == 2'd0) begin
          head_d = resp_entry;
        end else begin
          tail_d = resp_entry;
        end
        count_d = level_after_pop + 2'd1;
      end else begin
        count_d = level_after_pop;
      end
    end
  end

  // State registers with asynchronous reset back to the reset PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= ResetPc;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      // NOTE: queue storage is reset too, so out_* read zero during reset
      // rather than leaking a word fetched before it.
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  assign rom_addr  = pc_q[AddrWidth+1:2];
  assign out_valid = (count_q != 2'd0);
  assign out_instr = head_q.instr;
  assign out_pc    = head_q.pc;
  assign out_fault = head_q.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit against a synchronous ROM model. A monitor
// compares every accepted output against the expected instruction stream
// (consecutive PCs from the last reset or redirect) held in a scoreboard queue.
module tb_fetch_unit;

  localparam int          DEPTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] ROM_END  = 32'(DEPTH * 4);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  logic [31:0] rom_mem [DEPTH];

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [31:0] next_pc;

  fetch_unit #(.Width(32), .Depth(DEPTH), .ResetPc(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the address is sampled.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what decode must see for a given fetch PC.
  function automatic exp_t model(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    if (pc >= ROM_END) begin
      e.instr = 32'h0;
      e.fault = 1'b1;
    end else begin
      e.instr = rom_mem[pc[6:2]];
      e.fault = 1'b0;
    end
    return e;
  endfunction

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(model(next_pc));
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Monitor / scoreboard: a pop at the coming edge must carry the next
  // expected entry; reset or redirect restarts the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      next_pc = RESET_PC;
      refill();
    end else begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("pop_pc", out_pc, e.pc);
        check("pop_instr", out_instr, e.instr);
        check("pop_fault", 32'(out_fault), 32'(e.fault));
      end
      if (redirect_valid) begin
        exp_q.delete();
        next_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      refill();
    end
  end

  task automatic edge_drive();
    @(posedge clk);
    #1;
  endtask

  // Expect `zeros` sampled cycles with out_valid low, then the given head.
  task automatic expect_start(input string tag, input int zeros,
                              input logic [31:0] pc, input logic [31:0] instr);
    for (int i = 0; i < zeros; i++) begin
      @(negedge clk);
      check({tag, "_gap"}, 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, instr);
  endtask

  task automatic expect_streaming(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(tag, 32'(out_valid), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    logic [4:0] frozen_addr;
    frozen_addr = '0;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 32'(i + 100);
    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state, then release and measure the 2-edge latency.
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_fault", 32'(out_fault), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'(RESET_PC[6:2]));
    rst = 1'b0;
    expect_start("boot", 1, 32'h0, 32'd100);

    // Full-rate stream across the ROM end (0x7C -> 0x80 faults).
    expect_streaming("stream_valid", 40);

    // Backpressure: pc must freeze and output must restart without a bubble.
    edge_drive();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_drive();
      if (i == 4) out_ready = 1'b1;
      @(negedge clk);
      if (i == 0) frozen_addr = rom_addr;
      else check("stall_rom_addr", 32'(rom_addr), 32'(frozen_addr));
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    expect_streaming("resume_valid", 10);

    // Redirect while the queue is full, no pop on the redirect edge.
    edge_drive();
    out_ready = 1'b0;
    repeat (3) edge_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h23;
    edge_drive();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    expect_start("redir_full", 2, 32'h20, 32'd108);
    expect_streaming("redir_full_stream", 6);

    // Redirect in the same cycle as a pop.
    edge_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    edge_drive();
    redirect_valid = 1'b0;
    expect_start("redir_pop", 2, 32'h40, 32'd116);
    expect_streaming("redir_pop_stream", 4);

    // PC wrap through the top of the address space back into the ROM.
    edge_drive();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    edge_drive();
    redirect_valid = 1'b0;
    expect_start("wrap", 2, 32'hFFFF_FFF8, 32'd0);
    expect_streaming("wrap_stream", 8);

    // Random backpressure and redirects; the monitor checks every pop.
    for (int i = 0; i < 400; i++) begin
      edge_drive();
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom()
                                                   : 32'($urandom_range(0, 160));
    end
    edge_drive();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (6) edge_drive();

    // Asynchronous reset between edges while a read is outstanding.
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_instr", out_instr, 32'd0);
    check("arst_fault", 32'(out_fault), 32'd0);
    check("arst_rom_addr", 32'(rom_addr), 32'(RESET_PC[6:2]));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_start("reboot", 1, 32'h0, 32'd100);
    expect_streaming("reboot_stream", 5);

    edge_drive();
    out_ready = 1'b0;
    repeat (2) edge_drive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
